// File: rtl/dequantizer_stream.sv
// dequantizer_stream: serializes packed narrow fixed-point words one lane per
// cycle and widens each lane to the accumulator format (sign-extend + align).
// Optional build macro: DEQUANT_ZERO_POINT_EN adds a per-word zero_point that
// is subtracted from each lane before widening.
module dequantizer_stream #(
    parameter int unsigned WIDTH_IN  = 8,
    parameter int unsigned FRAC_IN   = 4,
    parameter int unsigned WIDTH_OUT = 16,
    parameter int unsigned FRAC_OUT  = 8,
    parameter int unsigned LANES     = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [LANES*WIDTH_IN-1:0]                    in_data,
    input  logic                                         in_last,
`ifdef DEQUANT_ZERO_POINT_EN
    input  logic [WIDTH_IN-1:0]                          zero_point,
`endif
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [WIDTH_OUT-1:0]                         out_data,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] out_lane,
    output logic                                         out_last
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned SHIFT  = FRAC_OUT - FRAC_IN;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [LANE_W-1:0]         lane_cnt;
    logic [LANES*WIDTH_IN-1:0] buf_data;
    logic                      buf_last;
`ifdef DEQUANT_ZERO_POINT_EN
    logic [WIDTH_IN-1:0]       buf_zp;
`endif

    logic                      last_lane;
    logic                      in_fire;
    logic                      out_fire;
    logic [WIDTH_IN-1:0]       lane_val;
    logic signed [WIDTH_IN:0]  diff;
    logic signed [WIDTH_OUT-1:0] wide;

    assign last_lane = (lane_cnt == LANE_W'(LANES - 1));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a final-lane handshake either chains the next word or idles
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = EMIT;
            EMIT: if (out_ready && last_lane && !in_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; in_ready follows out_ready only at the final lane
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = rst_n;
            EMIT: begin
                out_valid = 1'b1;
                in_ready  = rst_n && last_lane && out_ready;
            end
            default: ;
        endcase
    end

    // Word buffer and lane counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            buf_data <= '0;
            buf_last <= 1'b0;
`ifdef DEQUANT_ZERO_POINT_EN
            buf_zp   <= '0;
`endif
        end else if (in_fire) begin
            lane_cnt <= '0;
            buf_data <= in_data;
            buf_last <= in_last;
`ifdef DEQUANT_ZERO_POINT_EN
            buf_zp   <= zero_point;
`endif
        end else if (out_fire) begin
            lane_cnt <= last_lane ? '0 : lane_cnt + LANE_W'(1);
        end
    end

    // Widening of the current lane; one extra bit keeps the subtraction exact
    always_comb begin
        lane_val = buf_data[int'(lane_cnt)*WIDTH_IN +: WIDTH_IN];
`ifdef DEQUANT_ZERO_POINT_EN
        diff = $signed({lane_val[WIDTH_IN-1], lane_val})
             - $signed({buf_zp[WIDTH_IN-1], buf_zp});
`else
        diff = $signed({lane_val[WIDTH_IN-1], lane_val});
`endif
        wide     = WIDTH_OUT'(diff);
        out_data = wide <<< SHIFT;
    end

    assign out_lane = lane_cnt;
    assign out_last = buf_last && last_lane;

endmodule

// File: tb/tb_dequantizer_stream.sv
// Directed bench for dequantizer_stream at default parameters (8/4 -> 16/8, 4 lanes).
module tb_dequantizer_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
`ifdef DEQUANT_ZERO_POINT_EN
    logic [7:0]  zero_point;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dequantizer_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef DEQUANT_ZERO_POINT_EN
        .zero_point(zero_point),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [31:0]      data;
        logic             last;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        int   elem;
        int   wi;
        logic acc;

        vecs[0] = '{32'h807FF818, 1'b0, {16'hF800, 16'h07F0, 16'hFF80, 16'h0180}};
        vecs[1] = '{32'h1001FF00, 1'b1, {16'h0100, 16'h0010, 16'hFFF0, 16'h0000}};
        vecs[2] = '{32'h817EC040, 1'b0, {16'hF810, 16'h07E0, 16'hFC00, 16'h0400}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
`ifdef DEQUANT_ZERO_POINT_EN
        zero_point = 8'h00;
`endif
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_lane", 32'(out_lane), 0);
        chk("rst_out_last", 32'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_out_valid", 32'(out_valid), 0);
            chk("idle_in_ready", 32'(in_ready), 1);
        end

        // Table-driven single words
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1;
            in_data  = vecs[v].data;
            in_last  = vecs[v].last;
            @(negedge clk);
            in_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                chk("tbl_valid", 32'(out_valid), 1);
                chk("tbl_data", 32'(out_data), 32'(vecs[v].exp[j]));
                chk("tbl_lane", 32'(out_lane), j);
                chk("tbl_last", 32'(out_last), 32'(vecs[v].last && j == 3));
                @(negedge clk);
            end
            chk("tbl_idle", 32'(out_valid), 0);
        end

        // Back-to-back: three words, in_valid held, last on the third
        wi       = 0;
        elem     = 0;
        in_valid = 1'b1;
        in_data  = vecs[0].data;
        in_last  = 1'b0;
        for (int cyc = 0; cyc < 40 && elem < 12; cyc++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("b2b_data", 32'(out_data), 32'(vecs[elem / 4].exp[elem % 4]));
                chk("b2b_lane", 32'(out_lane), elem % 4);
                chk("b2b_last", 32'(out_last), 32'(elem == 11));
                chk("b2b_in_ready", 32'(in_ready), 32'(elem % 4 == 3));
                elem++;
            end else if (elem > 0) begin
                chk("b2b_gap", 32'(out_valid), 1);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                wi++;
                if (wi < 3) begin
                    in_data = vecs[wi].data;
                    in_last = (wi == 2);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("b2b_count", elem, 12);
        chk("b2b_idle", 32'(out_valid), 0);

        // Backpressure at lane 2
        in_valid = 1'b1;
        in_data  = vecs[0].data;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready0", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'h07F0);
            chk("bp_lane", 32'(out_lane), 2);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        chk("bp_rel_lane2", 32'(out_lane), 2);
        @(negedge clk);
        chk("bp_lane3", 32'(out_lane), 3);
        chk("bp_data3", 32'(out_data), 32'hF800);
        chk("bp_last3", 32'(out_last), 0);
        @(negedge clk);
        chk("bp_idle", 32'(out_valid), 0);

        // Reset mid-word after lane 1 is emitted
        in_valid = 1'b1;
        in_data  = vecs[2].data;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rmw_lane0", 32'(out_lane), 0);
        @(negedge clk);
        chk("rmw_lane1", 32'(out_lane), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmw_out_valid", 32'(out_valid), 0);
        chk("rmw_in_ready", 32'(in_ready), 0);
        chk("rmw_out_data", 32'(out_data), 0);
        chk("rmw_out_lane", 32'(out_lane), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rmw_rel_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rmw_no_stale", 32'(out_valid), 0);
        end

`ifdef DEQUANT_ZERO_POINT_EN
        // Zero point subtraction; mid-word change is ignored
        zero_point = 8'h10;
        in_valid   = 1'b1;
        in_data    = 32'h7F108018;
        in_last    = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("zp_lane0", 32'(out_data), 32'h0080);
        @(negedge clk);
        zero_point = 8'h00;
        chk("zp_lane1", 32'(out_data), 32'hF700);
        @(negedge clk);
        chk("zp_lane2", 32'(out_data), 32'h0000);
        @(negedge clk);
        chk("zp_lane3", 32'(out_data), 32'h06F0);
        @(negedge clk);
        chk("zp_idle", 32'(out_valid), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dequantizer_stream.md
# dequantizer_stream

- Streaming widening converter: the inverse of the narrowing quantizer on the NPU datapath.
- Accepts packed words of `LANES` narrow signed fixed-point values from the activation/weight buffer.
- Serializes them one lane per cycle and re-expresses each value in the wide accumulator fixed-point format, using sign-extension and fractional alignment.
- Sits between on-chip memory read-out and the MAC array; valid/ready on both sides.

## Interface

- `WIDTH_IN`, 8: narrow element width, two's complement.
- `FRAC_IN`, 4: narrow fractional bits.
- `WIDTH_OUT`, 16: wide element width.
- `FRAC_OUT`, 8: wide fractional bits. Legal only if `FRAC_OUT >= FRAC_IN` and `WIDTH_OUT-FRAC_OUT >= WIDTH_IN-FRAC_IN+1`.
- `LANES`, 4: elements per input word, ≥2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_data` in `LANES*WIDTH_IN`: packed word; lane i = `in_data[i*WIDTH_IN +: WIDTH_IN]`.
- `in_last` in 1: word is the last of a tensor row.
- `zero_point` in `WIDTH_IN`: present only with `DEQUANT_ZERO_POINT_EN`.
- `out_valid` out 1: output element valid.
- `out_ready` in 1: consumer accepts the element.
- `out_data` out `WIDTH_OUT`: converted element.
- `out_lane` out `max(1,$clog2(LANES))`: index of the current lane.
- `out_last` out 1: high on the final lane of a word captured with `in_last`=1.

## Operation

- **FSM states:** IDLE (buffer empty), EMIT (buffer holds a word).
- **Word capture:** on the in-handshake (`in_valid && in_ready`), latch `in_data`, `in_last` and (when enabled) `zero_point` into the buffer; set `lane_cnt` to 0; go to EMIT.
- **`in_ready`:**
  - 1 in IDLE.
  - In EMIT, 1 only when `lane_cnt==LANES-1 && out_ready`, so the next word is captured in the same cycle as the final lane's handshake.
  - 0 while `rst_n` is low.
- **Lane stepping in EMIT:** `out_valid`=1. On each out-handshake:
  - `lane_cnt` < `LANES-1`: `lane_cnt` increments.
  - Final lane with no new word captured: return to IDLE.
  - Final lane with a new word captured: stay in EMIT, `lane_cnt`=0.
- **Stall:** with `out_ready`=0, `out_data`, `out_lane` and `out_last` hold stable, and `lane_cnt` does not advance.
- **Conversion** (combinational from the buffered lane):
  - Compute `d = in_lane`, or `in_lane - zp` when enabled, in `WIDTH_IN+1` signed bits.
  - Sign-extend `d` to `WIDTH_OUT`, then shift left by `FRAC_OUT-FRAC_IN`.
  - Exact; no rounding or overflow is possible under the legal parameters.
- **`out_last`:** equals the buffered `in_last` AND `lane_cnt==LANES-1`.
- **Reset:** asynchronous.
  - FSM to IDLE; `lane_cnt`, buffer and captured `zero_point` to 0.
  - `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0.
  - Reset mid-word discards the remaining lanes without emitting them.

## Timing

- **Latency:** a word accepted at edge k presents lane 0 (`out_valid`=1) after edge k; lane j follows j accepted output cycles later.
- **Throughput:** 1 element/cycle sustained when `in_valid` and `out_ready` are held high. This means one word per `LANES` cycles, with no bubble between words.
- **Rules:** no combinational path from `in_valid` to `out_valid`. `in_ready` depends combinationally on `out_ready` only in EMIT at the final lane.
- **Protocol:** upstream holds `in_data` stable until accepted. Downstream may deassert `out_ready` at any cycle.

## Configuration

- Macro: `DEQUANT_ZERO_POINT_EN`.
- **Defined:**
  - The `zero_point` port exists and is sampled with each word.
  - It is subtracted per lane before widening.
  - A `zero_point` change mid-word has no effect until the next word is captured.
- **Undefined:** the port is absent and the conversion is pure sign-extend-and-shift. Timing is identical in both builds.

## Test plan

All scenarios use the defaults (8/4 → 16/8, `LANES`=4).

- **Basic conversion:** word {lane0..3}={0x18,0xF8,0x7F,0x80}, `out_ready`=1 → `out_data` 0x0180, 0xFF80, 0x07F0, 0xF800 on 4 consecutive cycles; `out_lane` 0..3.
- **Back-to-back:** three words with `in_last` on the third, `in_valid` held high → 12 contiguous `out_valid` cycles with no gap. `in_ready` pulses only on the final-lane handshakes. `out_last`=1 only on element 12.
- **Backpressure:** `out_ready`=0 for 5 cycles at lane 2 → `out_data`/`out_lane` stay constant and `in_ready`=0. Release → lanes 2,3 are emitted, then IDLE.
- **Reset mid-word:** `rst_n` low after lane 1 is emitted → `out_valid`=0 immediately. After release, `in_ready`=1 and no stale lanes are emitted.
- **Zero point (`DEQUANT_ZERO_POINT_EN`):** `zero_point`=0x10, lanes {0x18,0x80,0x10,0x7F} → 0x0080, 0xF700, 0x0000, 0x06F0. Changing `zero_point` to 0 during lane 1 does not alter lanes 1–3.
- **Idle:** `in_valid`=0 for 10 cycles after reset → `out_valid`=0 and `in_ready`=1 throughout.
